// File: rtl/usb_cmd_pkg.sv
// Shared types and constants for the USB command interpreter and its response sequencer.
package usb_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_W1,
    GET_W2,
    GET_CK,
    EXEC,
    WAIT_ACK,
    RSP
  } state_t;

  localparam logic [3:0] OP_PING  = 4'h0;
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;

  localparam int unsigned ST_CK_ERR = 0;
  localparam int unsigned ST_BAD_OP = 1;
  localparam int unsigned ST_BUS_TO = 2;

  localparam logic [15:0] DEF_CMD_HEADER = 16'hC0DE;
  localparam logic [15:0] DEF_RSP_HEADER = 16'hDA7A;

endpackage

// File: rtl/usb_rsp_sequencer.sv
// Emits the 5-word response packet under out_full back-pressure, appending a
// running checksum of the first four words as the final word.
module usb_rsp_sequencer
  import usb_cmd_pkg::*;
#(
  parameter logic [15:0] RSP_HEADER = DEF_RSP_HEADER
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] w1,
  input  logic [15:0] data,
  input  logic [15:0] status,
  input  logic        out_full,
  output logic [15:0] out_data,
  output logic        out_we,
  output logic        done
);

  logic [2:0]  idx_q, idx_d;
  logic [15:0] sum_q, sum_d;
  logic [15:0] word;

  always_comb begin
    word = sum_q;
    case (idx_q)
      3'd0:    word = RSP_HEADER;
      3'd1:    word = w1;
      3'd2:    word = data;
      3'd3:    word = status;
      default: word = sum_q;
    endcase

    out_we   = en && !out_full;
    out_data = en ? word : '0;
    done     = out_we && (idx_q == 3'd4);

    idx_d = idx_q;
    sum_d = sum_q;
    if (out_we) begin
      if (done) begin
        idx_d = '0;
        sum_d = '0;
      end else begin
        idx_d = idx_q + 3'd1;
        sum_d = sum_q + word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      sum_q <= '0;
    end else begin
      idx_q <= idx_d;
      sum_q <= sum_d;
    end
  end

endmodule

// File: rtl/usb_cmd_interpreter.sv
// Parses 4-word host command packets, runs one register-bus transaction and
// returns a 5-word response. Optional mid-packet watchdog: USB_CMD_WDOG_EN.
module usb_cmd_interpreter
  import usb_cmd_pkg::*;
#(
  parameter logic [15:0] CMD_HEADER  = DEF_CMD_HEADER,
  parameter logic [15:0] RSP_HEADER  = DEF_RSP_HEADER,
`ifdef USB_CMD_WDOG_EN
  parameter int unsigned WDOG_CYCLES = 65535,
`endif
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_data,
  input  logic        in_empty,
  output logic        in_re,
  output logic [15:0] out_data,
  output logic        out_we,
  input  logic        out_full,
  output logic [11:0] reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [15:0] reg_rdata,
  input  logic        reg_ack,
  output logic        busy
);

  localparam logic [15:0] ACK_LAST = 16'(ACK_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] ck_q, ck_d;
  logic [15:0] w1_q, w1_d;
  logic [11:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] data_q, data_d;
  logic [2:0]  flags_q, flags_d;
  logic [15:0] ack_cnt_q, ack_cnt_d;
  logic        rsp_done;
`ifdef USB_CMD_WDOG_EN
  localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES);
  logic [15:0] gap_q, gap_d;
`endif

  always_comb begin
    state_d   = state_q;
    ck_d      = ck_q;
    w1_d      = w1_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    data_d    = data_q;
    flags_d   = flags_q;
    ack_cnt_d = ack_cnt_q;
    in_re     = 1'b0;
    reg_we    = 1'b0;
    reg_re    = 1'b0;

    case (state_q)
      IDLE: begin
        in_re = !in_empty;
        if (in_re && (in_data == CMD_HEADER)) begin
          ck_d    = in_data;
          flags_d = '0;
          state_d = GET_W1;
        end
      end
      GET_W1: begin
        in_re = !in_empty;
        if (in_re) begin
          w1_d    = in_data;
          addr_d  = in_data[11:0];
          ck_d    = ck_q + in_data;
          state_d = GET_W2;
        end
      end
      GET_W2: begin
        in_re = !in_empty;
        if (in_re) begin
          wdata_d = in_data;
          ck_d    = ck_q + in_data;
          state_d = GET_CK;
        end
      end
      GET_CK: begin
        in_re = !in_empty;
        if (in_re) begin
          flags_d[ST_CK_ERR] = (ck_q != in_data);
          state_d            = EXEC;
        end
      end
      EXEC: begin
        // Non-bus outcomes (PING, bad checksum, bad opcode) echo W2 as data.
        ack_cnt_d = '0;
        data_d    = wdata_q;
        state_d   = RSP;
        if (!flags_q[ST_CK_ERR]) begin
          case (w1_q[15:12])
            OP_PING: ;
            OP_WRITE: begin
              reg_we  = 1'b1;
              state_d = WAIT_ACK;
            end
            OP_READ: begin
              reg_re  = 1'b1;
              state_d = WAIT_ACK;
            end
            default: flags_d[ST_BAD_OP] = 1'b1;
          endcase
        end
      end
      WAIT_ACK: begin
        if (reg_ack) begin
          state_d = RSP;
          if (w1_q[15:12] == OP_READ) data_d = reg_rdata;
        end else if (ack_cnt_q == ACK_LAST) begin
          flags_d[ST_BUS_TO] = 1'b1;
          data_d             = '0;
          state_d            = RSP;
        end else begin
          ack_cnt_d = ack_cnt_q + 16'd1;
        end
      end
      RSP: begin
        if (rsp_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef USB_CMD_WDOG_EN
    gap_d = '0;
    if ((state_q == GET_W1) || (state_q == GET_W2) || (state_q == GET_CK)) begin
      if (in_re) begin
        gap_d = '0;
      end else if (gap_q == WDOG_LAST) begin
        gap_d   = '0;
        state_d = IDLE;
      end else begin
        gap_d = gap_q + 16'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ck_q      <= '0;
      w1_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      data_q    <= '0;
      flags_q   <= '0;
      ack_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ck_q      <= ck_d;
      w1_q      <= w1_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      data_q    <= data_d;
      flags_q   <= flags_d;
      ack_cnt_q <= ack_cnt_d;
    end
  end

`ifdef USB_CMD_WDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gap_q <= '0;
    else        gap_q <= gap_d;
  end
`endif

  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign busy      = (state_q != IDLE);

  usb_rsp_sequencer #(
    .RSP_HEADER(RSP_HEADER)
  ) u_rsp (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state_q == RSP),
    .w1      (w1_q),
    .data    (data_q),
    .status  ({13'b0, flags_q}),
    .out_full(out_full),
    .out_data(out_data),
    .out_we  (out_we),
    .done    (rsp_done)
  );

endmodule

// File: tb/tb_usb_cmd_interpreter.sv
// Self-checking bench: FIFO and register-slave models, table and random packets
// compared against a packet-level model of the command protocol.
module tb_usb_cmd_interpreter;

  localparam int unsigned ACK_TO = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        in_empty = 1'b1;
  logic        in_re;
  logic [15:0] out_data;
  logic        out_we;
  logic        out_full = 1'b0;
  logic [11:0] reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [15:0] reg_rdata = 16'h0;
  logic        reg_ack = 1'b0;
  logic        busy;

  usb_cmd_interpreter #(
    .CMD_HEADER (16'hC0DE),
    .RSP_HEADER (16'hDA7A),
    .ACK_TIMEOUT(ACK_TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_empty (in_empty),
    .in_re    (in_re),
    .out_data (out_data),
    .out_we   (out_we),
    .out_full (out_full),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_rdata(reg_rdata),
    .reg_ack  (reg_ack),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // FWFT command FIFO model: pops happen on the posedge where in_re was high
  logic [15:0] in_q[$];
  int          pops = 0;
  logic        re_s = 1'b0;

  always @(negedge clk) re_s = in_re;

  always @(posedge clk) begin
    #1;
    if (re_s && (in_q.size() > 0)) begin
      void'(in_q.pop_front());
      pops++;
    end
    in_empty = (in_q.size() == 0);
    in_data  = (in_q.size() > 0) ? in_q[0] : 16'h0;
  end

  // Output / bus monitor
  logic [15:0] rsp_q[$];
  logic [29:0] bus_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_we) rsp_q.push_back(out_data);
      if (reg_we || reg_re) bus_q.push_back({reg_we, reg_re, reg_addr, reg_wdata});
      if (out_full) check("no_we_when_full", {31'b0, out_we}, 32'h0);
    end
  end

  // Register slave: acks ack_delay cycles after the strobe cycle
  int          ack_delay = 1;
  logic [15:0] rd_val = 16'h0;

  always begin
    @(negedge clk);
    if (rst_n && (reg_we || reg_re)) begin
      repeat (ack_delay) @(posedge clk);
      #1;
      reg_ack   = 1'b1;
      reg_rdata = rd_val;
      @(posedge clk);
      #1;
      reg_ack   = 1'b0;
      reg_rdata = ~rd_val;
    end
  end

  typedef struct {
    logic [3:0]  op;
    logic [11:0] addr;
    logic [15:0] data;
    logic [15:0] ck_delta;
    int          delay;
    logic [15:0] rdata;
    int          bp;
    int          garbage;
  } vec_t;

  task automatic run_pkt(input vec_t v, input string tag);
    logic [15:0] w0, w1, w3, exp_data, exp_status;
    logic [15:0] exp_w[5];
    int          exp_bus;  // 0 none, 1 write, 2 read
    int          p0, cyc;
    bit          bp_done;
    logic [15:0] act;

    w0 = 16'hC0DE;
    w1 = {v.op, v.addr};
    w3 = w0 + w1 + v.data + v.ck_delta;

    exp_bus    = 0;
    exp_data   = v.data;
    exp_status = 16'h0000;
    if (v.ck_delta != 16'h0) begin
      exp_status = 16'h0001;
    end else if (v.op == 4'h0) begin
      exp_status = 16'h0000;
    end else if (v.op == 4'h1 || v.op == 4'h2) begin
      exp_bus = (v.op == 4'h1) ? 1 : 2;
      if (v.delay > int'(ACK_TO)) begin
        exp_data   = 16'h0000;
        exp_status = 16'h0004;
      end else if (v.op == 4'h2) begin
        exp_data = v.rdata;
      end
    end else begin
      exp_status = 16'h0002;
    end
    exp_w[0] = 16'hDA7A;
    exp_w[1] = w1;
    exp_w[2] = exp_data;
    exp_w[3] = exp_status;
    exp_w[4] = 16'hDA7A + w1 + exp_data + exp_status;

    ack_delay = v.delay;
    rd_val    = v.rdata;
    rsp_q.delete();
    bus_q.delete();
    p0 = pops;

    @(posedge clk);
    #1;
    for (int g = 0; g < v.garbage; g++) in_q.push_back(16'h1111 * 16'(g + 1));
    in_q.push_back(w0);
    in_q.push_back(w1);
    in_q.push_back(v.data);
    in_q.push_back(w3);

    cyc     = 0;
    bp_done = (v.bp == 0);
    while (rsp_q.size() < 5 && cyc < 800) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!bp_done && rsp_q.size() >= 2) begin
        out_full = 1'b1;
        repeat (v.bp) @(posedge clk);
        #1;
        out_full = 1'b0;
        bp_done  = 1'b1;
      end
    end
    check({tag, "_rsp_wait"}, {31'b0, (cyc < 800)}, 32'h1);
    repeat (8) @(posedge clk);
    #1;

    check({tag, "_rsp_count"}, rsp_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      act = (rsp_q.size() > i) ? rsp_q[i] : 16'hxxxx;
      check($sformatf("%s_rsp_w%0d", tag, i), {16'h0, act}, {16'h0, exp_w[i]});
    end
    check({tag, "_bus_count"}, bus_q.size(), (exp_bus != 0) ? 1 : 0);
    if (exp_bus != 0 && bus_q.size() > 0) begin
      check({tag, "_bus_kind"}, {30'b0, bus_q[0][29:28]}, (exp_bus == 1) ? 32'h2 : 32'h1);
      check({tag, "_bus_addr"}, {20'b0, bus_q[0][27:16]}, {20'b0, v.addr});
      if (exp_bus == 1) check({tag, "_bus_wdata"}, {16'b0, bus_q[0][15:0]}, {16'b0, v.data});
    end
    check({tag, "_pops"}, pops - p0, v.garbage + 4);
    check({tag, "_idle"}, {31'b0, busy}, 32'h0);
  endtask

  vec_t tbl[9];
  vec_t rv;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{op:4'h1, addr:12'h123, data:16'hBEEF, ck_delta:16'h0, delay:1,   rdata:16'h0,    bp:0,  garbage:0};
    tbl[1] = '{op:4'h2, addr:12'h010, data:16'h0000, ck_delta:16'h0, delay:3,   rdata:16'h55AA, bp:0,  garbage:0};
    tbl[2] = '{op:4'h0, addr:12'h000, data:16'h1234, ck_delta:16'h0, delay:1,   rdata:16'h0,    bp:0,  garbage:2};
    tbl[3] = '{op:4'h1, addr:12'h123, data:16'hBEEF, ck_delta:16'h1, delay:1,   rdata:16'h0,    bp:0,  garbage:0};
    tbl[4] = '{op:4'h2, addr:12'h040, data:16'h0000, ck_delta:16'h0, delay:256, rdata:16'h9999, bp:0,  garbage:0};
    tbl[5] = '{op:4'h7, addr:12'h321, data:16'hA5A5, ck_delta:16'h0, delay:1,   rdata:16'h0,    bp:0,  garbage:0};
    tbl[6] = '{op:4'h2, addr:12'hABC, data:16'h0F0F, ck_delta:16'h0, delay:2,   rdata:16'h1357, bp:10, garbage:0};
    tbl[7] = '{op:4'h1, addr:12'hFFF, data:16'h4242, ck_delta:16'h0, delay:255, rdata:16'h0,    bp:0,  garbage:1};
    tbl[8] = '{op:4'h2, addr:12'h777, data:16'h8001, ck_delta:16'hFFFF, delay:1, rdata:16'h2222, bp:0, garbage:1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_re",     {31'b0, in_re},     32'h0);
    check("rst_out_we",    {31'b0, out_we},    32'h0);
    check("rst_out_data",  {16'b0, out_data},  32'h0);
    check("rst_reg_we",    {31'b0, reg_we},    32'h0);
    check("rst_reg_re",    {31'b0, reg_re},    32'h0);
    check("rst_reg_addr",  {20'b0, reg_addr},  32'h0);
    check("rst_reg_wdata", {16'b0, reg_wdata}, 32'h0);
    check("rst_busy",      {31'b0, busy},      32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 9; i++) run_pkt(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 24; i++) begin
      int unsigned r;
      r  = $urandom_range(0, 9);
      rv.op       = (r < 3) ? 4'h0 : (r < 6) ? 4'h1 : (r < 9) ? 4'h2 : 4'($urandom_range(3, 15));
      rv.addr     = 12'($urandom);
      rv.data     = 16'($urandom);
      rv.ck_delta = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0;
      rv.delay    = $urandom_range(1, 6);
      rv.rdata    = 16'($urandom);
      rv.bp       = $urandom_range(0, 3);
      rv.garbage  = $urandom_range(0, 2);
      run_pkt(rv, $sformatf("rnd%0d", i));
    end

    // Asynchronous reset with a partial packet in flight
    @(posedge clk);
    #1;
    in_q.push_back(16'hC0DE);
    in_q.push_back(16'h1456);
    repeat (6) @(posedge clk);
    #1;
    check("midpkt_busy", {31'b0, busy}, 32'h1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    in_q.delete();
    #1;
    check("midrst_busy",     {31'b0, busy},      32'h0);
    check("midrst_reg_addr", {20'b0, reg_addr},  32'h0);
    check("midrst_in_re",    {31'b0, in_re},     32'h0);
    check("midrst_out_we",   {31'b0, out_we},    32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rv = '{op:4'h0, addr:12'h055, data:16'h6789, ck_delta:16'h0, delay:1, rdata:16'h0, bp:0, garbage:0};
    run_pkt(rv, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_cmd_interpreter.md
Name: usb_cmd_interpreter

Overview:
- Consumes the host command stream that the USB slave-FIFO path writes into the EP4 command FIFO.
- Reads words from that FIFO's read side (first-word-fall-through) and parses fixed 4-word command packets.
- Executes register write/read transactions on a simple register bus.
- Pushes a fixed 5-word response packet into the EP8 response FIFO write side, for return to the host.

Parameters:
- CMD_HEADER, 16'hC0DE, required first word of a command packet
- RSP_HEADER, 16'hDA7A, first word of every response packet
- ACK_TIMEOUT, 255, max cycles to wait for reg_ack before declaring a bus error
- WDOG_CYCLES, 65535, max idle cycles between words inside a packet (optional feature only)

Ports:
- clk  in  1  FIFO clock, same as the USB FIFO_CLOCK domain
- rst_n  in  1  asynchronous active-low reset
- in_data  in  16  command FIFO read data, FWFT, valid when !in_empty
- in_empty  in  1  command FIFO empty
- in_re  out  1  command FIFO read enable; pops the current word
- out_data  out  16  response FIFO write data
- out_we  out  1  response FIFO write enable
- out_full  in  1  response FIFO full
- reg_addr  out  12  register address
- reg_wdata  out  16  register write data
- reg_we  out  1  write strobe, single cycle
- reg_re  out  1  read strobe, single cycle
- reg_rdata  in  16  read data, valid with reg_ack
- reg_ack  in  1  transaction complete
- busy  out  1  high when not in IDLE

Behaviour:
- Reset: in_re=0, out_we=0, out_data=0, reg_we=0, reg_re=0, reg_addr=0, reg_wdata=0, busy=0; state=IDLE; all counters=0.
- in_re is asserted only when !in_empty and the state accepts a word. One word is consumed per asserted cycle.
- Command packet format:
  - W0 = CMD_HEADER
  - W1 = {op[3:0], addr[11:0]}
  - W2 = data
  - W3 = checksum, equal to (W0+W1+W2) mod 2^16
- Opcodes: 0x0 PING (no bus access), 0x1 WRITE, 0x2 READ. Any other opcode sets status bit1.
- IDLE:
  - Pops words until one equals CMD_HEADER, then goes to GET_W1.
  - Non-header words are discarded silently; no response is sent.
- GET_W1, GET_W2, GET_CK:
  - Each state pops one word and latches it.
  - The running checksum is accumulated in a 16-bit register; carry is discarded.
- Checksum check at the end of GET_CK:
  - Mismatch sets status bit0 and skips execution.
  - A response is still sent, with data = W2.
- EXEC: issues exactly one reg_we or reg_re pulse, with reg_addr and reg_wdata held stable until the response starts, then goes to WAIT_ACK. PING goes directly to RSP.
- WAIT_ACK:
  - reg_ack ends the wait. For READ, reg_rdata is captured. For WRITE, the data word is W2.
  - If ACK_TIMEOUT cycles pass without reg_ack, status bit2 is set, data = 16'h0000, and the state goes to RSP.
  - reg_ack arriving on the same cycle as the timeout counts as ack; no timeout is flagged.
- RSP: writes 5 words in order: RSP_HEADER, W1 echo, data, status {13'b0, bus_to, bad_op, ck_err}, checksum of the previous four words.
  - out_we is asserted only when !out_full.
  - A word index 0..4 advances only on a write; the index holds while out_full is high.
  - After word 4, return to IDLE.
- No input is popped during EXEC, WAIT_ACK or RSP, so back-to-back packets are processed strictly in order.
- Latency: the first response word appears no earlier than 2 cycles after W3 is popped (EXEC plus one).
- Asynchronous reset mid-packet discards the partial packet; outputs take their reset values immediately.

Optional Feature:
- USB_CMD_WDOG_EN defined:
  - A 16-bit gap counter runs in GET_W1, GET_W2 and GET_CK while in_empty is high, and clears on every pop.
  - When the counter reaches WDOG_CYCLES, the partial packet is dropped, the state returns to IDLE, and no response is sent.
- Not defined: the counter and comparator are absent, and the interpreter waits indefinitely mid-packet.

Decomposition:
- Package usb_cmd_pkg holds:
  - the state enum (IDLE, GET_W1, GET_W2, GET_CK, EXEC, WAIT_ACK, RSP)
  - opcode constants
  - status bit indices
  - default CMD_HEADER and RSP_HEADER values
- One natural sub-module, usb_rsp_sequencer: the 5-word response emitter with full back-pressure, the word index and the output checksum.

Test Plan:
- WRITE: push C0DE, 1123, BEEF, checksum -> one reg_we with addr=0x123 and wdata=BEEF; response DA7A, 1123, BEEF, 0000, checksum.
- READ with reg_rdata=0x55AA and ack after 3 cycles: push C0DE, 2010, 0000, checksum -> one reg_re with addr=0x010; response data word 55AA, status 0000.
- Garbage then packet: push 1111, 2222, then a valid PING -> exactly one response; the two garbage words are dropped with no output.
- Bad checksum: WRITE packet with W3 off by 1 -> no reg_we; response status 0001, data = W2.
- READ with no ack -> after 255 cycles, response data 0000, status 0004; opcode 0x7 -> status 0002, no bus strobe.
- Back-pressure: hold out_full high for 10 cycles in the middle of a response -> no out_we while full; the 5 response words are unchanged and in order; no extra input pops.
